// File: rtl/i2c_mt9v034_target.sv
// MT9V034-style I2C register target: 8-bit register pointer, 16-bit big-endian data,
// auto-increment, and a strobe that reports every committed register write.
module i2c_mt9v034_target #(
    parameter logic [6:0]  DEV_ADDR     = 7'h48,
    parameter logic [15:0] CHIP_VERSION = 16'h1313
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic        busy,
    output logic        reg_wr_en,
    output logic [7:0]  reg_wr_addr,
    output logic [15:0] reg_wr_data
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_DEV, ST_DEV_ACK, ST_REG, ST_REG_ACK,
        ST_WR_HI, ST_WR_HI_ACK, ST_WR_LO, ST_WR_LO_ACK,
        ST_RD_HI, ST_RD_HI_MACK, ST_RD_LO, ST_RD_LO_MACK, ST_WAIT_STOP
    } state_t;

    // [0],[1] synchronize, [2] is the history stage used for edge detection
    logic [2:0] scl_sync_q, sda_sync_q;
    logic       scl_rise_q, scl_fall_q, start_q, stop_q, sda_bit_q;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic [7:0]  hi_q, hi_d, lo_q, lo_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [15:0] shadow_q, shadow_d;
    logic        rw_q, rw_d;
    logic        busy_q, busy_d;
    logic        sda_oe_q, sda_oe_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;

    logic [15:0] mem_q [256];
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [15:0] mem_wdata;

    logic [7:0]  rx_byte;
    logic        locked;

    assign rx_byte = {shift_q, sda_bit_q};
    assign locked  = (mem_q[8'hFE] == 16'hDEAD);

    // Sync flops reset to 1 so an idle bus never produces a spurious edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_bit_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], scl_in};
            sda_sync_q <= {sda_sync_q[1:0], sda_in};
            scl_rise_q <= scl_sync_q[1] & ~scl_sync_q[2];
            scl_fall_q <= ~scl_sync_q[1] & scl_sync_q[2];
            start_q    <= ~sda_sync_q[1] & sda_sync_q[2] & scl_sync_q[1] & scl_sync_q[2];
            stop_q     <= sda_sync_q[1] & ~sda_sync_q[2] & scl_sync_q[1] & scl_sync_q[2];
            sda_bit_q  <= sda_sync_q[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            shift_q   <= 7'd0;
            hi_q      <= 8'd0;
            lo_q      <= 8'd0;
            ptr_q     <= 8'd0;
            shadow_q  <= 16'd0;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
            sda_oe_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 8'd0;
            wr_data_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            ptr_q     <= ptr_d;
            shadow_q  <= shadow_d;
            rw_q      <= rw_d;
            busy_q    <= busy_d;
            sda_oe_q  <= sda_oe_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Register file lives in flops so that reset restores its contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) begin
                mem_q[i] <= (i == 0) ? CHIP_VERSION : ((i == 254) ? 16'hBEEF : 16'h0000);
            end
        end else if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_q) begin
            state_d = ST_DEV;
        end else if (stop_q) begin
            state_d = ST_IDLE;
        end else if (scl_rise_q) begin
            case (state_q)
                ST_DEV:        if (cnt_q == 3'd7)
                                   state_d = (rx_byte[7:1] == DEV_ADDR) ? ST_DEV_ACK : ST_WAIT_STOP;
                ST_DEV_ACK:    state_d = rw_q ? ST_RD_HI : ST_REG;
                ST_REG:        if (cnt_q == 3'd7) state_d = ST_REG_ACK;
                ST_REG_ACK:    state_d = ST_WR_HI;
                ST_WR_HI:      if (cnt_q == 3'd7) state_d = ST_WR_HI_ACK;
                ST_WR_HI_ACK:  state_d = ST_WR_LO;
                ST_WR_LO:      if (cnt_q == 3'd7) state_d = ST_WR_LO_ACK;
                ST_WR_LO_ACK:  state_d = ST_WR_HI;
                ST_RD_HI:      if (cnt_q == 3'd7) state_d = ST_RD_HI_MACK;
                ST_RD_HI_MACK: state_d = sda_bit_q ? ST_WAIT_STOP : ST_RD_LO;
                ST_RD_LO:      if (cnt_q == 3'd7) state_d = ST_RD_LO_MACK;
                ST_RD_LO_MACK: state_d = sda_bit_q ? ST_WAIT_STOP : ST_RD_HI;
                default:       state_d = state_q;
            endcase
        end
    end

    always_comb begin
        logic [7:0] rd_byte;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        ptr_d     = ptr_q;
        shadow_d  = shadow_q;
        rw_d      = rw_q;
        busy_d    = busy_q;
        sda_oe_d  = sda_oe_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = {hi_q, lo_q};
        rd_byte   = (state_q == ST_RD_HI) ? shadow_q[15:8] : shadow_q[7:0];

        if (start_q) begin
            cnt_d    = 3'd0;
            sda_oe_d = 1'b0;
        end else if (stop_q) begin
            cnt_d    = 3'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (scl_rise_q) begin
            case (state_q)
                ST_DEV, ST_REG, ST_WR_HI, ST_WR_LO, ST_RD_HI, ST_RD_LO: begin
                    cnt_d   = cnt_q + 3'd1;
                    shift_d = rx_byte[6:0];
                end
                default: ;
            endcase
            if (cnt_q == 3'd7) begin
                case (state_q)
                    ST_DEV: begin
                        busy_d = (rx_byte[7:1] == DEV_ADDR);
                        rw_d   = rx_byte[0];
                    end
                    ST_REG:   ptr_d = rx_byte;
                    ST_WR_HI: hi_d  = rx_byte;
                    ST_WR_LO: lo_d  = rx_byte;
                    default: ;
                endcase
            end
            if (state_q == ST_WR_LO_ACK) begin
                // Register 0 is read-only; lock discards everything except the unlock register
                if (ptr_q != 8'h00 && (!locked || ptr_q == 8'hFE)) begin
                    mem_we    = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = {hi_q, lo_q};
                end
                ptr_d = ptr_q + 8'd1;
            end
            if (state_q == ST_RD_LO_MACK && !sda_bit_q) begin
                ptr_d = ptr_q + 8'd1;
            end
        end else if (scl_fall_q) begin
            case (state_q)
                ST_DEV_ACK, ST_REG_ACK, ST_WR_HI_ACK, ST_WR_LO_ACK: sda_oe_d = 1'b1;
                ST_RD_HI, ST_RD_LO: begin
                    if (state_q == ST_RD_HI && cnt_q == 3'd0) begin
                        shadow_d = mem_q[ptr_q];
                        sda_oe_d = ~mem_q[ptr_q][15];
                    end else begin
                        sda_oe_d = ~rd_byte[3'd7 - cnt_q];
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    assign sda_oe      = sda_oe_q;
    assign busy        = busy_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;

endmodule

// File: tb/tb_i2c_mt9v034_target.sv
// Bench for i2c_mt9v034_target: a bit-banged I2C master drives directed transactions;
// expected commits and bus responses go into queues that a monitor process drains.
`timescale 1ns/1ps
module tb_i2c_mt9v034_target;

    localparam int Q = 100;  // quarter SCL period = 10 clk

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_bus;
    logic        sda_oe, busy, reg_wr_en;
    logic [7:0]  reg_wr_addr;
    logic [15:0] reg_wr_data;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_wr_q [$];
    logic [7:0]  exp_bus_q [$];
    string       exp_name_q [$];
    logic [7:0]  obs_bus_q [$];

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_mt9v034_target #(.DEV_ADDR(7'h48), .CHIP_VERSION(16'h1313)) dut (
        .clk(clk), .rst_n(rst_n), .scl_in(scl_m), .sda_in(sda_bus),
        .sda_oe(sda_oe), .busy(busy), .reg_wr_en(reg_wr_en),
        .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Monitor: compares commit strobes and master-observed bus responses against expectations
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && reg_wr_en) begin
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit: got addr %h data %h, expected no commit",
                             reg_wr_addr, reg_wr_data);
                end else begin
                    check("commit", {8'h00, reg_wr_addr, reg_wr_data}, {8'h00, exp_wr_q.pop_front()});
                end
            end
            while (obs_bus_q.size() > 0) begin
                if (exp_bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got %h, expected nothing", obs_bus_q.pop_front());
                end else begin
                    check(exp_name_q.pop_front(), {24'h0, obs_bus_q.pop_front()},
                          {24'h0, exp_bus_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #(2ms);
        $display("FAIL watchdog: simulation did not complete, expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    task automatic i2c_start();
        sda_m = 1'b1; #(Q);
        scl_m = 1'b1; #(Q);
        sda_m = 1'b0; #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #(Q);
        scl_m = 1'b1; #(Q);
        sda_m = 1'b1; #(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    #(Q);
        scl_m = 1'b1; #(Q);
        #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; #(Q);
        scl_m = 1'b1; #(Q);
        b = sda_bus;  #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic exp_ack);
        logic a;
        exp_bus_q.push_back({7'h0, exp_ack});
        exp_name_q.push_back($sformatf("ack_after_%02h", d));
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(a);
        obs_bus_q.push_back({7'h0, ~a});
    endtask

    task automatic read_byte(input logic [7:0] exp_d, input logic mack);
        logic [7:0] d;
        logic b;
        exp_bus_q.push_back(exp_d);
        exp_name_q.push_back("read_byte");
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~mack);
        obs_bus_q.push_back(d);
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [15:0] d, input logic commits);
        $display("txn write reg %02h = %04h (commit expected %0d)", a, d, commits);
        if (commits) exp_wr_q.push_back({a, d});
        i2c_start();
        write_byte(8'h90, 1'b1);
        write_byte(a, 1'b1);
        write_byte(d[15:8], 1'b1);
        write_byte(d[7:0], 1'b1);
        i2c_stop();
    endtask

    task automatic read_reg(input logic [7:0] a, input logic [15:0] exp_d);
        $display("txn read reg %02h expecting %04h", a, exp_d);
        i2c_start();
        write_byte(8'h90, 1'b1);
        write_byte(a, 1'b1);
        i2c_start();
        write_byte(8'h91, 1'b1);
        read_byte(exp_d[15:8], 1'b1);
        read_byte(exp_d[7:0], 1'b0);
        check("sda_released_after_nack", {31'h0, sda_oe}, 32'h0);
        i2c_stop();
    endtask

    initial begin
        // Reset state
        repeat (5) @(posedge clk);
        #1;
        check("reset_outputs", {6'h0, sda_oe, busy, reg_wr_en, reg_wr_addr, reg_wr_data},
              {6'h0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000});
        rst_n = 1'b1;
        #(4 * Q);

        // Single write
        $display("txn write reg 0d = 0330 with busy tracking");
        exp_wr_q.push_back({8'h0D, 16'h0330});
        i2c_start();
        write_byte(8'h90, 1'b1);
        write_byte(8'h0D, 1'b1);
        check("busy_during_write", {31'h0, busy}, 32'h1);
        write_byte(8'h03, 1'b1);
        write_byte(8'h30, 1'b1);
        i2c_stop();
        check("busy_after_stop", {31'h0, busy}, 32'h0);
        read_reg(8'h0D, 16'h0330);

        // Read of chip version
        read_reg(8'h00, 16'h1313);

        // Sequential write wrapping from 0xFF to read-only 0x00
        $display("txn sequential write ff = 1111, 00 = 2222");
        exp_wr_q.push_back({8'hFF, 16'h1111});
        i2c_start();
        write_byte(8'h90, 1'b1);
        write_byte(8'hFF, 1'b1);
        write_byte(8'h11, 1'b1);
        write_byte(8'h11, 1'b1);
        write_byte(8'h22, 1'b1);
        write_byte(8'h22, 1'b1);
        i2c_stop();
        read_reg(8'hFF, 16'h1111);
        read_reg(8'h00, 16'h1313);

        // Lock / unlock
        write_reg(8'hFE, 16'hDEAD, 1'b1);
        write_reg(8'h0C, 16'h0001, 1'b0);
        read_reg(8'h0C, 16'h0000);
        write_reg(8'hFE, 16'hBEEF, 1'b1);
        write_reg(8'h0C, 16'h0001, 1'b1);
        read_reg(8'h0C, 16'h0001);

        // Address mismatch, then a valid transaction
        $display("txn address 92 (mismatch)");
        i2c_start();
        write_byte(8'h92, 1'b0);
        check("busy_after_mismatch", {31'h0, busy}, 32'h0);
        i2c_stop();
        write_reg(8'h05, 16'hA55A, 1'b1);

        // Abort after MSB byte: no commit
        $display("txn aborted write to 02");
        i2c_start();
        write_byte(8'h90, 1'b1);
        write_byte(8'h02, 1'b1);
        write_byte(8'h01, 1'b1);
        i2c_stop();

        // Reset mid read byte: bit 7 of 0x1313 is 0, so the target is pulling SDA
        $display("txn reset during read of 00");
        i2c_start();
        write_byte(8'h90, 1'b1);
        write_byte(8'h00, 1'b1);
        i2c_start();
        write_byte(8'h91, 1'b1);
        sda_m = 1'b1; #(Q);
        scl_m = 1'b1; #(Q);
        check("drive_before_reset", {31'h0, sda_oe}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("sda_oe_on_reset", {31'h0, sda_oe}, 32'h0);
        check("busy_on_reset", {31'h0, busy}, 32'h0);
        #(Q - 1);
        scl_m = 1'b0; #(Q);
        rst_n = 1'b1; #(Q);
        i2c_stop();
        read_reg(8'h02, 16'h0000);
        read_reg(8'h0D, 16'h0000);
        read_reg(8'hFE, 16'hBEEF);

        #(10 * Q);
        check("pending_commits", exp_wr_q.size(), 32'h0);
        check("pending_bus_items", exp_bus_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_mt9v034_target.md
# i2c_mt9v034_target

Synthesizable I2C target (responder) that models the MT9V034 two-wire register interface: 8-bit register address, 16-bit big-endian register data, sequential auto-increment. It sits opposite the sensor-configuration master in simulation and FPGA loopback builds. It lets the configuration path be exercised without a sensor, and it exports every committed write to downstream logic.

## Interface
Parameters:
- DEV_ADDR, 7'h48, 7-bit target address (0x90 write / 0x91 read on the bus)
- CHIP_VERSION, 16'h1313, read-only content of register 0x00

Ports:
- clk  in  1  system clock; must be at least 10× the SCL frequency
- rst_n  in  1  asynchronous, active-low reset
- scl_in  in  1  SCL from pad, asynchronous
- sda_in  in  1  SDA from pad, asynchronous
- sda_oe  out  1  1 = pull SDA low; 0 = release (open-drain)
- busy  out  1  high from an address-matched START until STOP, or until the next START that does not match
- reg_wr_en  out  1  one-cycle pulse per committed register write
- reg_wr_addr  out  8  address of the committed write
- reg_wr_data  out  16  data of the committed write

## Operation
- **Input conditioning**
  - scl_in and sda_in each pass through a 2-FF synchronizer plus one history stage.
  - SCL rise/fall and SDA rise/fall are detected as edges of the synchronized signals.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
  - Data is sampled on SCL rise. sda_oe changes only on detected SCL fall.
- **Register file**
  - 256 × 16. Reset contents: 0x00 = CHIP_VERSION, 0xFE = 16'hBEEF, all others 0x0000.
  - Register 0x00 is never writable.
  - Lock: when reg[0xFE] == 16'hDEAD, writes to any address other than 0xFE are ACKed but discarded, with no reg_wr_en pulse.
  - Writing 16'hBEEF to 0xFE unlocks.
- **FSM states:** IDLE, DEV, DEV_ACK, REG, REG_ACK, WR_HI, WR_HI_ACK, WR_LO, WR_LO_ACK, RD_HI, RD_HI_MACK, RD_LO, RD_LO_MACK, WAIT_STOP.
  - A 3-bit bit counter shifts MSB first.
  - **DEV:** after 8 bits, compare [7:1] with DEV_ADDR.
    - Mismatch → WAIT_STOP with no ACK.
    - Match → DEV_ACK, R/W bit latched.
  - **DEV_ACK:**
    - W → REG.
    - R → RD_HI, loading shadow = reg[ptr].
  - **REG:** the 8 received bits load the address pointer ptr; then REG_ACK → WR_HI.
  - **WR_HI / WR_LO:** bytes are ACKed.
    - The LSB ACK commits {hi, lo} to reg[ptr], pulses reg_wr_en (subject to the 0x00 and lock rules), and increments ptr.
    - Then WR_HI again, for sequential writes.
  - **RD_HI / RD_LO:** the target drives shadow bits: bit = 0 → sda_oe = 1; bit = 1 → sda_oe = 0.
    - In RD_*_MACK, sda_in is sampled on SCL rise.
    - Master ACK (0) after LSB → ptr increments, shadow reloads, go to RD_HI.
    - Master ACK after MSB → go to RD_LO.
    - Master NACK (1) → WAIT_STOP.
  - **WAIT_STOP:** ignores bits; sda_oe = 0.
- **Global overrides**, valid in any state:
  - START → DEV. A repeated START keeps ptr, which is how reads are set up.
  - STOP → IDLE.
  - Any partially received word is discarded and does not commit.
- **Pointer rules:**
  - ptr is 8 bits and wraps 0xFF → 0x00.
  - ptr persists across transactions; it resets to 0x00.

## Timing
- **Reset values:** sda_oe = 0, busy = 0, reg_wr_en = 0, reg_wr_addr = 0x00, reg_wr_data = 0x0000, FSM = IDLE, ptr = 0x00.
- **Detection latency:** a pad edge is recognized 3 clk after it occurs (2 sync stages plus the edge register).
- **ACK drive:** sda_oe asserts 1 clk after the detected SCL fall ending bit 8, and releases 1 clk after the detected SCL fall ending the ACK bit.
- **Read data:** shadow loads 1 clk after the detected SCL fall that ends the preceding ACK. Bit 7 is driven on that same edge.
- **Write commit:** reg_wr_en pulses for exactly 1 clk, 1 clk after the SCL rise that samples the LSB ACK slot. reg_wr_addr and reg_wr_data are valid in that cycle and hold until the next commit.
- **Simultaneous START and SCL edge:** START wins and the bit is not counted.
- **Asynchronous reset mid-transfer:** releases SDA immediately and restores register contents to their reset values.

## Test plan
- **Write:** START, 0x90, 0x0D, 0x03, 0x30, STOP → 4 ACKs; reg_wr_en once with addr 0x0D, data 0x0330; busy falls after STOP.
- **Read:**
  - Stimulus: START 0x90 0x00, repeated START 0x91, read 2 bytes, master NACK, STOP.
  - Required: returns 0x13, 0x13; sda_oe = 0 after the NACK.
- **Sequential with wrap:** write 0xFF with 0x1111 then 0x2222 in one transaction → reg[0xFF] = 0x1111, reg[0x00] unchanged at 0x1313, exactly 1 reg_wr_en pulse; a subsequent read of 0x00 returns 0x1313.
- **Lock:** write 0xFE = 0xDEAD, then 0x0C = 0x0001 → both ACKed, only the 0xFE write pulses reg_wr_en; reg[0x0C] reads 0x0000; after writing 0xFE = 0xBEEF, a 0x0C write commits.
- **Address mismatch:** START, 0x92 → no ACK, busy stays 0, no pulses, and the next valid transaction succeeds.
- **Abort:**
  - Stimulus: STOP after only the MSB byte (0x02 write, data 0x01), then rst_n pulsed during a read byte.
  - Required: no commit; sda_oe = 0 immediately on reset; reg[0x02] = 0x0000.
